// File: rtl/seqdet_pkg.sv
// ============================================================================
// Module : seqdet_pkg
// Brief  : Shared mode constants and limits for the serial pattern detector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqdet_pkg;
  localparam int MODE_MEALY   = 0;
  localparam int MODE_MOORE   = 1;
  localparam int OVL_OFF      = 0;
  localparam int OVL_ON       = 1;
  localparam int SEQDET_MAX_W = 16;
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter with synchronous clear that sticks at all-ones.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module : seq_detector_param
// Brief  : Parametrised serial bit-pattern detector with valid, clear and
//          saturating match counter; Mealy/Moore and overlap selectable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int                   PATTERN_W = 3,
  parameter logic [PATTERN_W-1:0] PATTERN   = 3'b101,
  parameter int                   OVERLAP   = OVL_ON,
  parameter int                   MOORE     = MODE_MEALY,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  if ((PATTERN_W < 2) || (PATTERN_W > SEQDET_MAX_W)) begin : g_bad_width
    $error("seq_detector_param: PATTERN_W must be in 2..16");
  end

  // r_fill doubles as the state: 0 = EMPTY, 1..W-2 = FILLING, W-1 = PRIMED.
  localparam logic [4:0] c_primed = 5'(PATTERN_W - 1);

  logic [PATTERN_W-2:0] r_hist;
  logic [4:0]           r_fill;
  logic [PATTERN_W-1:0] w_window;
  logic                 w_accept;
  logic                 w_hit;

  assign w_window = {r_hist, in};
  assign w_accept = in_valid & ~clr;
  assign w_hit    = w_accept & (r_fill == c_primed) & (w_window == PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      r_hist <= w_window[PATTERN_W-2:0];
      if (w_hit && (OVERLAP == OVL_OFF)) begin
        r_fill <= '0;
      end else if (r_fill != c_primed) begin
        r_fill <= r_fill + 5'd1;
      end
    end
  end

  if (MOORE == MODE_MOORE) begin : g_moore
    logic r_match_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_match_q <= 1'b0;
      end else if (clr) begin
        r_match_q <= 1'b0;
      end else begin
        r_match_q <= w_hit;
      end
    end

    assign match = r_match_q;
  end else begin : g_mealy
    assign match = w_hit;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(w_hit),
    .q  (match_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module : tb_seq_detector_param
// Brief  : Self-checking bench driving six detector configurations in parallel.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;
  import seqdet_pkg::*;

  localparam int N = 6;
  // 0: default, 1: no overlap, 2: Moore, 3: W4 0000, 4: W4 1111, 5: CNT_W=2
  localparam int CFG_W    [N] = '{3, 3, 3, 4, 4, 3};
  localparam int CFG_PAT  [N] = '{5, 5, 5, 0, 15, 5};
  localparam int CFG_OVL  [N] = '{1, 0, 1, 1, 1, 1};
  localparam int CFG_MOO  [N] = '{0, 0, 1, 0, 0, 0};
  localparam int CFG_CMAX [N] = '{255, 255, 255, 255, 255, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       m   [N];
  logic [7:0] cnt [N];
  logic [1:0] cnt_sat;

  assign cnt[5] = {6'd0, cnt_sat};

  always #5 clk = ~clk;

  seq_detector_param u_def (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in(din), .match(m[0]), .match_count(cnt[0]));
  seq_detector_param #(.OVERLAP(OVL_OFF)) u_novl (.clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in(din), .match(m[1]), .match_count(cnt[1]));
  seq_detector_param #(.MOORE(MODE_MOORE)) u_moore (.clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in(din), .match(m[2]), .match_count(cnt[2]));
  seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b0000)) u_p0 (.clk(clk), .rst(rst),
    .clr(clr), .in_valid(in_valid), .in(din), .match(m[3]), .match_count(cnt[3]));
  seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1111)) u_p1 (.clk(clk), .rst(rst),
    .clr(clr), .in_valid(in_valid), .in(din), .match(m[4]), .match_count(cnt[4]));
  seq_detector_param #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in(din), .match(m[5]), .match_count(cnt_sat));

  int checks = 0;
  int errors = 0;

  // Reference model: bits accepted since the last restart, match count, Moore flag.
  int mbits [N];
  int mn    [N];
  int mcnt  [N];
  bit mq    [N];

  bit last_match [N];
  int last_cnt   [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mbits[k] = 0;
      mn[k]    = 0;
      mcnt[k]  = 0;
      mq[k]    = 1'b0;
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model after posedge.
  task automatic step(input bit c, input bit v, input bit b);
    bit hit [N];
    int mask;
    clr = c;
    in_valid = v;
    din = b;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      mask = (1 << CFG_W[k]) - 1;
      hit[k] = v && !c && (mn[k] >= CFG_W[k] - 1) &&
               ((((mbits[k] << 1) | int'(b)) & mask) == CFG_PAT[k]);
      last_match[k] = m[k];
      last_cnt[k]   = int'(cnt[k]);
      chk($sformatf("match[%0d]", k), int'(m[k]), CFG_MOO[k] != 0 ? int'(mq[k]) : int'(hit[k]));
      chk($sformatf("count[%0d]", k), int'(cnt[k]), mcnt[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (c) begin
        mbits[k] = 0;
        mn[k]    = 0;
        mcnt[k]  = 0;
        mq[k]    = 1'b0;
      end else begin
        mq[k] = hit[k];
        if (v) begin
          mbits[k] = ((mbits[k] << 1) | int'(b)) & 16'hffff;
          mn[k]    = (hit[k] && CFG_OVL[k] == 0) ? 0 : mn[k] + 1;
        end
        if (hit[k] && mcnt[k] < CFG_CMAX[k]) mcnt[k] = mcnt[k] + 1;
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_match[%0d]", k), int'(m[k]), 0);
      chk($sformatf("rst_count[%0d]", k), int'(cnt[k]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit clr;
    bit vld;
    bit din;
    bit e_def;
    bit e_novl;
    bit e_moore;
    int c_def;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 1};
    tbl[4]  = '{0, 1, 1, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 0, 0, 1, 2};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 2};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 2};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Table: 1,0,1,0,1 stream, bubbles, clear, and 1,(3 bubbles),0,1.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].clr, tbl[i].vld, tbl[i].din);
      chk($sformatf("tbl%0d_def", i),   int'(last_match[0]), int'(tbl[i].e_def));
      chk($sformatf("tbl%0d_novl", i),  int'(last_match[1]), int'(tbl[i].e_novl));
      chk($sformatf("tbl%0d_moore", i), int'(last_match[2]), int'(tbl[i].e_moore));
      chk($sformatf("tbl%0d_cnt", i),   last_cnt[0], tbl[i].c_def);
    end

    // Reset mid-pattern discards the partial history.
    do_reset();
    step(0, 1, 1);
    step(0, 1, 0);
    do_reset();
    step(0, 1, 1);
    chk("rst_mid_match", int'(last_match[0]), 0);
    chk("rst_mid_count", int'(cnt[0]), 0);

    // All-zero pattern must not fire from zeroed history.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk($sformatf("zero_early%0d", i), int'(last_match[3]), 0);
    end
    step(0, 1, 0);
    chk("zero_fourth", int'(last_match[3]), 1);

    // All-ones pattern, overlapping: six 1s give three matches.
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    chk("ones_count", int'(cnt[4]), 3);

    // Saturation at 3 with CNT_W=2, then clear with a discarded bit.
    do_reset();
    step(0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      step(0, 1, 1);
    end
    chk("sat_count", int'(cnt[5]), 3);
    chk("sat_wide_count", int'(cnt[0]), 6);
    step(1, 1, 1);
    chk("clr_match", int'(last_match[5]), 0);
    chk("clr_count", int'(cnt[5]), 0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("clr_discard", int'(last_match[5]), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. It generalises the fixed single-pattern Mealy detector to any pattern width and value.
- Overlapping vs non-overlapping matching, and Mealy vs Moore output timing, are selected by parameter.
- Adds an input-valid qualifier, a synchronous clear, and a saturating match counter.
- Sits on a serial bit stream (UART/line-decoder side) and flags frame sync words or marker sequences to downstream control.

Parameters:
- PATTERN_W, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b101, pattern to detect. MSB is the oldest bit received, LSB the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- MOORE, 0, 0 = Mealy output (same cycle as final bit); 1 = Moore output (registered, one cycle later).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of history, fill level, counter and Moore output.
- in_valid  in  1  qualifies `in`; the bit is consumed only when high.
- in  in  1  serial data bit.
- match  out  1  match pulse.
- match_count  out  CNT_W  number of matches since reset/clr; saturates.

Behaviour:
- State:
  - hist[PATTERN_W-2:0]: last PATTERN_W-1 accepted bits.
  - fill: 0..PATTERN_W-1, number of valid history bits. It acts as the FSM state: EMPTY (0), FILLING (1..PATTERN_W-2), PRIMED (PATTERN_W-1).
  - cnt: match counter.
  - match_q: Moore output register.
- Reset (rst=1, async): hist=0, fill=0 (EMPTY), cnt=0, match_q=0. Outputs are match=0 and match_count=0 while rst is high.
- Window and hit:
  - window = {hist, in}.
  - hit = in_valid & ~clr & (fill==PATTERN_W-1) & (window==PATTERN).
  - No match is possible before PATTERN_W valid bits have been accepted. Zeroed history must never produce a false match (e.g. PATTERN=3'b001).
- Accepted bit (in_valid=1, clr=0): hist <= {hist[PATTERN_W-3:0], in}, i.e. hist <= window[PATTERN_W-2:0].
  - fill, no hit: fill <= min(fill+1, PATTERN_W-1).
  - fill on hit, OVERLAP=1: fill stays PATTERN_W-1.
  - fill on hit, OVERLAP=0: fill <= 0. The next match needs PATTERN_W fresh bits.
- in_valid=0: hist, fill and cnt hold. Bubbles do not break a partial pattern.
- Mealy output (MOORE=0): match = hit, combinational, asserted in the same cycle the final bit is presented.
- Moore output (MOORE=1):
  - match_q <= hit every cycle; match = match_q.
  - One-cycle pulse, one clock after the final bit. This is independent of in_valid in that cycle.
- Counter:
  - cnt <= cnt+1 on hit, saturating at 2^CNT_W-1 (no wrap).
  - match_count = cnt, registered. It updates the cycle after the hit.
- clr=1 (synchronous):
  - Next edge: hist=0, fill=0, cnt=0, match_q=0.
  - A bit presented with clr is discarded. Mealy match is forced 0 in that cycle.
  - clr has priority over in_valid.
- Reset mid-pattern: partial history is lost, and a full PATTERN_W bits are needed after release.
- Parameter illegal (PATTERN_W<2 or >16): elaboration-time error via generate-if $error.

Decomposition:
- Package seqdet_pkg:
  - localparams MODE_MEALY=0, MODE_MOORE=1, OVL_OFF=0, OVL_ON=1.
  - Max pattern width constant SEQDET_MAX_W=16.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, clr, inc, q). It is reused for match_count.
- Everything else lives in the top module.

Test Plan:
- Defaults (101, overlap, Mealy), in_valid=1, stream 1,0,1,0,1 -> match high in the cycles bits 3 and 5 are presented; match_count=2 one cycle after bit 5.
- OVERLAP=0, same stream 1,0,1,0,1 -> match only on bit 3; match_count=1; bits 4-5 refill history without matching.
- MOORE=1, stream 1,0,1 -> match low in the cycle bit 3 is presented, high for exactly one cycle on the next clock, then low.
- Stream 1,(in_valid=0 for 3 cycles),0,1 -> single match on the final 1. Then apply rst after 1,0 and send 1 -> no match; count reads 0.
- PATTERN_W=4, PATTERN=4'b0000, from reset send 0,0,0 -> no match (no false hit from zeroed history). Fourth 0 -> match. Then PATTERN=4'b1111, overlap, six 1s -> 3 matches, count=3.
- CNT_W=2, six overlapping 101 matches -> match_count saturates at 3. Then clr asserted together with in=1, in_valid=1 -> count=0, no match, the bit is discarded.
